// File: rtl/icdf_sign_restore_if.sv
// icdf_sign_restore_if: flag, magnitude and z-score handshakes of the inverse-CDF sign-restore stage.
interface icdf_sign_restore_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic                       flag_valid;
    logic                       flag_negate;
    logic                       flag_ready;
    logic                       mag_valid;
    logic [WIDTH-1:0]           mag_in;
    logic                       mag_ready;
    logic                       z_valid;
    logic                       z_ready;
    logic [WIDTH-1:0]           z;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic                       orphan_err;
    logic [15:0]                sat_count;

    modport master (
        output flag_valid, flag_negate, mag_valid, mag_in, z_ready,
        input  flag_ready, mag_ready, z_valid, z, occupancy, orphan_err, sat_count
    );

    modport slave (
        input  flag_valid, flag_negate, mag_valid, mag_in, z_ready,
        output flag_ready, mag_ready, z_valid, z, occupancy, orphan_err, sat_count
    );
endinterface

// File: rtl/icdf_sign_restore.sv
// icdf_sign_restore: pairs queued negate flags with returned |z|, clamps to ZMAX and restores the sign.
// Optional ICDF_SAT_COUNT_EN builds the saturating clamp-event counter behind sat_count.
module icdf_sign_restore #(
    parameter int               WIDTH = 32,
    parameter int               FRAC  = 16,
    parameter int               DEPTH = 8,
    parameter logic [WIDTH-1:0] ZMAX  = WIDTH'(8) << FRAC
) (
    input logic               clk,
    input logic               rst_n,
    icdf_sign_restore_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic             r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [OW-1:0]    r_occ;
    logic             r_zv, r_orphan;
    logic [WIDTH-1:0] r_z;
    logic             w_push, w_fire, w_free, w_sat;
    logic [WIDTH-1:0] w_m, w_z;

    assign w_free = !r_zv || bus.z_ready;
    assign w_push = bus.flag_valid && bus.flag_ready;
    assign w_fire = bus.mag_valid && bus.mag_ready;
    // Any set MSB means a huge unsigned magnitude, so it also clamps.
    assign w_sat  = bus.mag_in[WIDTH-1] || (bus.mag_in > ZMAX);
    assign w_m    = w_sat ? ZMAX : bus.mag_in;
    assign w_z    = r_mem[r_rp] ? -w_m : w_m;

    assign bus.flag_ready = r_occ != OW'(DEPTH);
    assign bus.mag_ready  = (r_occ != '0) && w_free;
    assign bus.z_valid    = r_zv;
    assign bus.z          = r_z;
    assign bus.occupancy  = r_occ;
    assign bus.orphan_err = r_orphan;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= bus.flag_negate;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_occ    <= '0;
            r_zv     <= 1'b0;
            r_z      <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_fire)
                r_rp <= r_rp + 1'b1;
            r_occ <= r_occ + OW'(w_push) - OW'(w_fire);
            if (w_fire) begin
                r_zv <= 1'b1;
                r_z  <= w_z;
            end else if (bus.z_ready) begin
                r_zv <= 1'b0;
            end
            if (bus.mag_valid && r_occ == '0 && w_free)
                r_orphan <= 1'b1;
        end
    end

`ifdef ICDF_SAT_COUNT_EN
    logic [15:0] r_sat;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_sat <= '0;
        else if (w_fire && w_sat && r_sat != 16'hFFFF)
            r_sat <= r_sat + 16'd1;
    end

    assign bus.sat_count = r_sat;
`else
    assign bus.sat_count = '0;
`endif
endmodule

// File: tb/tb_icdf_sign_restore.sv
// tb_icdf_sign_restore: directed test-plan sequences plus randomized traffic against a queue-based model.
module tb_icdf_sign_restore;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icdf_sign_restore_if #(.WIDTH(32), .DEPTH(8)) bus ();
    icdf_sign_restore #(.WIDTH(32), .FRAC(16), .DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          q[$];
    bit          m_zv = 0;
    logic [31:0] m_z = '0;
    bit          m_orph = 0;
    int          m_sat = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(bit rn, bit fv, bit fn, bit mv, logic [31:0] mag, bit zr);
        bit          push, fire, sat, neg;
        logic [31:0] m;
        rst_n = rn;
        bus.flag_valid = fv;
        bus.flag_negate = fn;
        bus.mag_valid = mv;
        bus.mag_in = mag;
        bus.z_ready = zr;
        #1;
        if (rn) begin
            check("flag_ready", 32'(bus.flag_ready), 32'(q.size() != 8));
            check("mag_ready", 32'(bus.mag_ready), 32'(q.size() != 0 && (!m_zv || zr)));
        end
        push = fv && q.size() != 8;
        fire = mv && q.size() != 0 && (!m_zv || zr);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_zv = 0;
            m_z = '0;
            m_orph = 0;
            m_sat = 0;
        end else begin
            if (mv && q.size() == 0 && (!m_zv || zr)) m_orph = 1;
            if (fire) begin
                sat = mag > 32'd524288;
                m = sat ? 32'd524288 : mag;
                neg = q.pop_front();
                m_z = neg ? 32'd0 - m : m;
                m_zv = 1;
                if (sat && m_sat != 65535) m_sat++;
            end else if (zr) begin
                m_zv = 0;
            end
            if (push) q.push_back(fn);
        end
        #1;
        check("z_valid", 32'(bus.z_valid), 32'(m_zv));
        check("z", bus.z, m_z);
        check("occupancy", 32'(bus.occupancy), 32'(q.size()));
        check("orphan_err", 32'(bus.orphan_err), 32'(m_orph));
`ifdef ICDF_SAT_COUNT_EN
        check("sat_count", 32'(bus.sat_count), 32'(m_sat));
`else
        check("sat_count", 32'(bus.sat_count), 32'd0);
`endif
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, '0, 1);
    endtask

    initial begin
        cyc(0, 0, 0, 0, '0, 0);
        cyc(0, 1, 1, 1, 32'h1234, 1);
        // basic sign restore
        cyc(1, 1, 1, 0, '0, 1);
        cyc(1, 1, 0, 0, '0, 1);
        cyc(1, 0, 0, 1, 32'h0001_0000, 1);
        check("basic_neg", bus.z, 32'hFFFF_0000);
        cyc(1, 0, 0, 1, 32'h0001_0000, 1);
        check("basic_pos", bus.z, 32'h0001_0000);
        idle(1);
        // clamp
        cyc(1, 1, 0, 0, '0, 1);
        cyc(1, 1, 1, 0, '0, 1);
        cyc(1, 0, 0, 1, 32'h0009_0000, 1);
        check("clamp_pos", bus.z, 32'h0008_0000);
        cyc(1, 0, 0, 1, 32'h8000_0000, 1);
        check("clamp_neg", bus.z, 32'hFFF8_0000);
        idle(1);
        // full FIFO and backpressure
        for (int i = 0; i < 9; i++) cyc(1, 1, 1'(i), 0, '0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 32'(i + 1) << 16, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 32'(i + 5) << 12, 1);
        idle(2);
        // same-cycle push and magnitude on an empty FIFO
        cyc(1, 1, 1, 1, 32'h0000_8000, 1);
        cyc(1, 0, 0, 1, 32'h0000_8000, 1);
        idle(1);
        check("same_cycle", bus.z, 32'hFFFF_8000);
        // orphan, sticky across traffic
        cyc(1, 0, 0, 1, 32'h0000_4000, 1);
        cyc(1, 1, 0, 0, '0, 1);
        cyc(1, 0, 0, 1, 32'h0000_4000, 1);
        idle(1);
        // reset mid-stream with 3 flags queued and z_valid held
        for (int i = 0; i < 4; i++) cyc(1, 1, 1'(i), 0, '0, 0);
        cyc(1, 0, 0, 1, 32'h0002_0000, 0);
        cyc(0, 1, 1, 1, 32'h0003_0000, 0);
        cyc(1, 1, 1, 0, '0, 1);
        cyc(1, 0, 0, 1, 32'h0002_0000, 1);
        idle(1);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) == 0 ? 32'($urandom) : 32'($urandom_range(0, 32'h0009_0000)),
                $urandom_range(0, 3) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
